// File: rtl/ecc_harq_scheduler.sv
// Round-robin HARQ scheduler feeding a shared ecc_encode: grants one flit, resends on NACK, drops after MAX_RETRY.
// Optional ACK timeout (implicit NACK) is enabled by defining HARQ_ACK_TIMEOUT_EN.
module ecc_harq_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*32-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_wvalid,
  output logic [39:0]           o_wdata,
  input  logic                  i_ack,
  input  logic                  i_nack,
  output logic                  o_busy,
  output logic [1:0]            o_retry_cnt,
  output logic                  o_drop,
  output logic [2:0]            o_drop_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam logic [1:0] MAX_RC = 2'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DROP} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] rr_ptr, held_idx, grant_idx, next_ptr;
  logic [31:0]      held_data;
  logic [31:0]      req_data [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic             grant_any;
  logic [CW-1:0]    scan_idx;
  logic [1:0]       retry_cnt;
  logic             nack_eff;
  logic             timeout;

`ifdef HARQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = (state == WAIT) && (to_cnt == TW'(ACK_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) req_data[k] = i_req_data[k*32 +: 32];
  end

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + CW'(i);
      if (scan_idx >= CW'(NUM_REQ)) scan_idx = scan_idx - CW'(NUM_REQ);
      if (!grant_any && i_req_valid[scan_idx[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[IDX_W-1:0];
        grant[scan_idx[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  assign next_ptr = (held_idx == IDX_W'(NUM_REQ - 1)) ? '0 : held_idx + 1'b1;
  assign nack_eff = !i_ack && (i_nack || timeout);

  // NOTE: every output and the next state get a default first so no latch is inferred.
  always_comb begin
    state_nx    = state;
    o_req_ready = '0;
    o_wvalid    = (state == SEND);
    o_wdata     = (state == SEND) ? {8'h00, held_data} : 40'h0;
    o_drop      = (state == DROP);
    o_drop_id   = (state == DROP) ? 3'(held_idx) : 3'd0;
    o_busy      = (state != IDLE);
    o_retry_cnt = retry_cnt;
    case (state)
      IDLE: if (grant_any) begin
        state_nx    = SEND;
        o_req_ready = grant;
      end
      SEND: state_nx = WAIT;
      WAIT: begin
        if (i_ack)         state_nx = IDLE;
        else if (nack_eff) state_nx = (retry_cnt == MAX_RC) ? DROP : SEND;
      end
      DROP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (i_areset) o_req_ready = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      held_idx  <= '0;
      retry_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant_any) begin
          held_idx  <= grant_idx;
          retry_cnt <= '0;
        end
        WAIT: begin
          if (i_ack) rr_ptr <= next_ptr;
          else if (nack_eff && retry_cnt != MAX_RC) retry_cnt <= retry_cnt + 2'd1;
        end
        DROP: rr_ptr <= next_ptr;
        default: ;
      endcase
    end
  end

  // NOTE: the payload register has no reset; o_wdata is gated by state, so its contents never leak.
  always_ff @(posedge i_aclk) begin
    if (state == IDLE && grant_any) held_data <= req_data[grant_idx];
  end

`ifdef HARQ_ACK_TIMEOUT_EN
  // Counter is held at zero outside WAIT, so it is clear on every WAIT entry.
  always_ff @(posedge i_aclk) begin
    if (i_areset || state != WAIT) to_cnt <= '0;
    else if (!i_ack && !i_nack && !timeout) to_cnt <= to_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ecc_harq_scheduler.sv
// Self-checking bench for ecc_harq_scheduler: table-driven transactions plus hand-written
// corner sequences; o_wdata is checked against a scoreboard queue filled at every expected send.
module tb_ecc_harq_scheduler;

  localparam int NUM_REQ = 4;
  localparam int MAX_RETRY = 3;

  logic         clk = 1'b0;
  logic         i_areset = 1'b1;
  logic [3:0]   i_req_valid = '0;
  logic [127:0] i_req_data = '0;
  logic [3:0]   o_req_ready;
  logic         o_wvalid;
  logic [39:0]  o_wdata;
  logic         i_ack = 1'b0;
  logic         i_nack = 1'b0;
  logic         o_busy;
  logic [1:0]   o_retry_cnt;
  logic         o_drop;
  logic [2:0]   o_drop_id;

  int n_cmp = 0;
  int n_bad = 0;
  logic [39:0] sb [$];

  typedef struct {
    logic [3:0] valid;
    int         exp_idx;
    int         nacks;
    bit         both;
  } vec_t;
  vec_t vecs [12];

  ecc_harq_scheduler #(.NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(16)) dut (
    .i_aclk(clk), .i_areset(i_areset), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_wvalid(o_wvalid), .o_wdata(o_wdata), .i_ack(i_ack),
    .i_nack(i_nack), .o_busy(o_busy), .o_retry_cnt(o_retry_cnt), .o_drop(o_drop),
    .o_drop_id(o_drop_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every cycle with o_wvalid must match the oldest expected flit.
  initial forever begin
    @(posedge clk);
    #3;
    if (o_wvalid) begin
      if (sb.size() == 0) check("unexpected_send", o_wvalid, 1'b0);
      else check("wdata", o_wdata, sb.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // One flit: grant, then `nacks` NACKs (drop once retries are exhausted), else ACK.
  task automatic run_txn(input logic [3:0] valid, input int exp_idx, input int nacks, input bit both);
    int waited = 0;
    int retry = 0;
    logic [39:0] exp_w;
    i_req_valid = valid;
    #1;
    while (o_req_ready == '0 && waited < 10) begin
      tick();
      waited++;
    end
    check("grant", o_req_ready, 64'(1) << exp_idx);
    if (o_req_ready == '0) return;
    exp_w = {8'h00, i_req_data[32*exp_idx +: 32]};
    sb.push_back(exp_w);
    tick();
    for (int a = 0; a < 8; a++) begin
      check("ready_low_send", o_req_ready, 0);
      check("wvalid_send", o_wvalid, 1);
      tick();
      check("retry_cnt", o_retry_cnt, retry);
      check("busy_wait", o_busy, 1);
      if (nacks > retry) begin
        i_nack = 1'b1;
        tick();
        i_nack = 1'b0;
        if (retry == MAX_RETRY) begin
          check("drop", o_drop, 1);
          check("drop_id", o_drop_id, exp_idx);
          check("wvalid_drop", o_wvalid, 0);
          tick();
          check("drop_one_cycle", o_drop, 0);
          break;
        end
        retry++;
        sb.push_back(exp_w);
      end else begin
        i_ack  = 1'b1;
        i_nack = both;
        tick();
        i_ack  = 1'b0;
        i_nack = 1'b0;
        check("idle_after_ack", o_busy, 0);
        check("retry_after_ack", o_retry_cnt, retry);
        break;
      end
    end
    i_req_valid = '0;
  endtask

  initial begin
    // Round-robin pointer is 3 after the two opening transactions.
    vecs[0]  = '{4'b1111, 3, 0, 1'b0};
    vecs[1]  = '{4'b1111, 0, 0, 1'b0};
    vecs[2]  = '{4'b1111, 1, 0, 1'b0};
    vecs[3]  = '{4'b1111, 2, 0, 1'b0};
    vecs[4]  = '{4'b1111, 3, 0, 1'b0};
    vecs[5]  = '{4'b0010, 1, 4, 1'b0};
    vecs[6]  = '{4'b0001, 0, 0, 1'b1};
    vecs[7]  = '{4'b1000, 3, 2, 1'b0};
    vecs[8]  = '{4'b0110, 1, 1, 1'b0};
    vecs[9]  = '{4'b0011, 0, 0, 1'b0};
    vecs[10] = '{4'b1101, 2, 0, 1'b0};
    vecs[11] = '{4'b0101, 0, 3, 1'b0};

    i_req_valid = 4'b1111;
    tick();
    tick();
    check("rst_ready", o_req_ready, 0);
    check("rst_wvalid", o_wvalid, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_busy", o_busy, 0);
    check("rst_retry", o_retry_cnt, 0);
    check("rst_drop", {o_drop, o_drop_id}, 0);
    i_req_valid = '0;
    i_areset = 1'b0;
    tick();

    i_req_data[31:0]  = 32'hA5A5_0001;
    i_req_data[95:64] = 32'h0000_0002;
    run_txn(4'b0101, 0, 0, 1'b0);
    run_txn(4'b0101, 2, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < NUM_REQ; k++) i_req_data[32*k +: 32] = 32'hC0DE_0000 | (t << 4) | k;
      run_txn(vecs[t].valid, vecs[t].exp_idx, vecs[t].nacks, vecs[t].both);
    end

    // Hold in WAIT with no response (rr_ptr is 1 here).
    i_req_valid = 4'b0010;
    #1;
    check("hold_grant", o_req_ready, 4'b0010);
    sb.push_back({8'h00, i_req_data[63:32]});
    tick();
    i_req_valid = '0;
    tick();
`ifdef HARQ_ACK_TIMEOUT_EN
    repeat (15) tick();
    check("to_no_send_yet", o_wvalid, 0);
    sb.push_back({8'h00, i_req_data[63:32]});
    tick();
    check("to_resend", o_wvalid, 1);
    check("to_retry", o_retry_cnt, 1);
    tick();
`else
    repeat (100) tick();
    check("hold_busy", o_busy, 1);
    check("hold_no_send", o_wvalid, 0);
    check("hold_retry", o_retry_cnt, 0);
`endif
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("hold_released", o_busy, 0);

    // Reset in WAIT with two retries outstanding (rr_ptr is 2, so requester 3 wins).
    i_req_valid = 4'b1000;
    #1;
    check("rw_grant", o_req_ready, 4'b1000);
    sb.push_back({8'h00, i_req_data[127:96]});
    tick();
    tick();
    for (int n = 0; n < 2; n++) begin
      i_nack = 1'b1;
      sb.push_back({8'h00, i_req_data[127:96]});
      tick();
      i_nack = 1'b0;
      tick();
    end
    check("rw_retry2", o_retry_cnt, 2);
    i_areset = 1'b1;
    tick();
    check("rw_ready", o_req_ready, 0);
    check("rw_outputs", {o_wvalid, o_wdata, o_busy, o_retry_cnt, o_drop, o_drop_id}, 0);
    tick();
    check("rw_no_drop", o_drop, 0);
    i_areset = 1'b0;
    run_txn(4'b1111, 0, 0, 1'b0);

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
